// File: rtl/bcd_xs3_seq_ctrl.sv
// Multi-digit BCD to excess-3 sequencer. It time-shares one external
// single-digit converter and handles one digit per clock, digit 0 first.
module bcd_xs3_seq_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [4*DIGITS-1:0]   in_bcd_i,
  output logic [3:0]            conv_in_o,
  input  logic [3:0]            conv_out_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*DIGITS-1:0]   out_xs3_o,
  output logic [DIGITS-1:0]     err_mask_o,
  output logic                  out_err_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0][3:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0][3:0]   xs3_q, xs3_d;
  logic [DIGITS-1:0]        err_q, err_d;
  logic [3:0]               cur_digit;
  logic                     digit_ok;

  assign cur_digit = bcd_q[idx_q];
  assign digit_ok  = (cur_digit <= 4'd9);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bcd_q   <= '0;
      xs3_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      xs3_q   <= xs3_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bcd_d       = bcd_q;
    xs3_d       = xs3_q;
    err_d       = err_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    conv_in_o   = 4'd0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          bcd_d   = in_bcd_i;
          xs3_d   = '0;
          err_d   = '0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        conv_in_o = cur_digit;
        // A non-BCD digit leaves the converter output floating; never capture it.
        xs3_d[idx_q] = digit_ok ? conv_out_i : 4'd0;
        err_d[idx_q] = ~digit_ok;
        if (idx_q == IW'(DIGITS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_xs3_o  = xs3_q;
  assign err_mask_o = err_q;
  assign out_err_o  = |err_q;

endmodule

// File: doc/bcd_xs3_seq_ctrl.md
# bcd_xs3_seq_ctrl

Sequencer that converts a packed multi-digit BCD word to excess-3 by time-sharing one combinational single-digit BCD-to-excess-3 converter, one digit per clock. It sits between an upstream valid/ready source and a downstream valid/ready sink, and drives the shared converter's 4-bit input. It screens each digit before use, so the converter's high-impedance output for non-BCD codes (>9) is never captured; such digits are flagged instead.

## Interface
- DIGITS, 4, number of BCD digits per word (≥1)
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset (one clock; reset asynchronous, active-low)
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word
- in_bcd  in  4*DIGITS  packed BCD word, digit 0 = in_bcd[3:0]
- conv_in  out  4  digit driven to shared converter
- conv_out  in  4  converter result (combinational, same cycle)
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts result
- out_xs3  out  4*DIGITS  packed excess-3 result, digit i at [4i+3:4i]
- err_mask  out  DIGITS  bit i set = input digit i was >9
- out_err  out  1  OR of err_mask

## Operation
- States: IDLE, CONV, DONE. Digit index idx, width max(1, $clog2(DIGITS)).
- IDLE: in_ready=1, conv_in=0. On in_valid: latch in_bcd, clear result and err_mask, idx=0, go CONV.
- CONV: in_ready=0, conv_in=latched digit[idx].
  - If digit[idx] ≤ 9: result slot idx ← conv_out.
  - If digit[idx] > 9: result slot idx ← 4'b0000, err_mask[idx] ← 1; conv_out ignored.
  - idx==DIGITS-1: go DONE; otherwise idx+1.
- DONE: out_valid=1, conv_in=0. out_xs3, err_mask and out_err stay stable until out_ready; on out_valid&&out_ready go IDLE.
- in_valid outside IDLE is ignored; the upstream holds it (in_ready=0).
- Digits are processed in ascending order, digit 0 first. Conversion is digit-independent with no carries between digits.
- out_xs3/err_mask hold their last values in IDLE and are cleared on the next acceptance.

## Timing
- Reset (asynchronous, immediate): state=IDLE, idx=0, in_ready=1, out_valid=0, conv_in=0, out_xs3=0, err_mask=0, out_err=0.
- Reset mid-CONV or mid-DONE: the word is discarded. No out_valid follows reset release.
- Word accepted at edge A (in_valid&&in_ready). Digit i is on conv_in during cycle A+1+i and is captured at edge A+1+i.
- out_valid rises after edge A+DIGITS, so latency is DIGITS cycles from acceptance.
- With out_ready held high, DONE lasts 1 cycle and IDLE lasts at least 1 cycle. Minimum acceptance spacing is DIGITS+2 cycles.
- in_ready and out_valid are Moore outputs (state decode only) and are never high simultaneously.
- conv_in is registered-state decode. It is glitch-free relative to clk and stable for the full cycle in which conv_out is sampled.
- DIGITS=1: CONV lasts exactly one cycle.

## Test plan
- DIGITS=4, in_bcd=16'h1234 → out_xs3=16'h4567, err_mask=0, out_err=0. out_valid is high 4 edges after acceptance. conv_in sequence is 4,3,2,1.
- in_bcd=16'h9090 → out_xs3=16'hC3C3; in_bcd=16'h0000 → 16'h3333, each with no error.
- in_bcd=16'h12A4 → out_xs3=16'h4507, err_mask=4'b0010, out_err=1. Bench drives conv_out=4'bzzzz for that digit; the result must contain no X/Z.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with 16'h5555. out_valid, out_xs3 and err_mask stay stable, in_ready=0, and the new word is not accepted. Release out_ready; IDLE follows, then 16'h5555 is accepted.
- Assert rst_n low asynchronously after 2 digits converted in CONV. All outputs go to reset values before the next clk edge. After release, in_ready=1 and no spurious out_valid appears; a fresh 16'h0987 yields 16'h3CBA.
- Back-to-back 16'h9999 then 16'h0102 with out_ready=1 and in_valid held high → 16'hCCCC then 16'h3435. Acceptance edges are exactly DIGITS+2=6 cycles apart.
